// File: rtl/fifo_msg_serializer.sv
// rtl/fifo_msg_serializer.sv - dequeues one 704-bit message and streams it out as 22 word beats
module fifo_msg_serializer #(
   parameter int WORDS = 22,
   parameter int WIDTH = 32
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic [WORDS*WIDTH-1:0] in_first,
   input  logic                   in_first__RDY,
   input  logic                   in_deq__RDY,
   output logic                   in_deq__ENA,
   input  logic                   out_word__RDY,
   output logic                   out_word__ENA,
   output logic [WIDTH-1:0]       out_word_v,
   output logic                   out_word_last,
   output logic                   busy,
   output logic [31:0]            msg_count
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_SEND = 1'b1;
   localparam logic [4:0] LAST_IDX = 5'(WORDS - 1);

   logic                   state_q, state_d;
   logic [4:0]             idx_q, idx_d;
   logic [WORDS*WIDTH-1:0] hold_q, hold_d;
   logic [31:0]            msg_count_q, msg_count_d;

   logic up_rdy;
   logic sending;
   logic is_last;
   logic last_xfer;

   assign up_rdy    = in_first__RDY & in_deq__RDY;
   assign sending   = (state_q == ST_SEND);
   assign is_last   = sending & (idx_q == LAST_IDX);
   assign last_xfer = is_last & out_word__RDY;

   // Reload from upstream on the final beat so consecutive messages leave no bubble.
   assign in_deq__ENA   = up_rdy & (~sending | last_xfer);
   assign out_word__ENA = sending & out_word__RDY;
   assign out_word_last = is_last;
   assign out_word_v    = sending ? hold_q[WIDTH*idx_q +: WIDTH] : '0;
   assign busy          = sending;
   assign msg_count     = msg_count_q;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      hold_d      = hold_q;
      msg_count_d = msg_count_q;
      if (in_deq__ENA) begin
         hold_d  = in_first;
         idx_d   = '0;
         state_d = ST_SEND;
      end else if (last_xfer) begin
         state_d = ST_IDLE;
      end
      if (out_word__ENA && !is_last)
         idx_d = idx_q + 5'd1;
      if (last_xfer)
         msg_count_d = msg_count_q + 32'd1;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         hold_q      <= '0;
         msg_count_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         hold_q      <= hold_d;
         msg_count_q <= msg_count_d;
      end
   end

endmodule

// File: tb/tb_fifo_msg_serializer.sv
// tb/tb_fifo_msg_serializer.sv - directed bench for fifo_msg_serializer
module tb_fifo_msg_serializer;

   logic         CLK = 1'b0;
   logic         RST;
   logic [703:0] in_first;
   logic         in_first__RDY;
   logic         in_deq__RDY;
   logic         in_deq__ENA;
   logic         out_word__RDY;
   logic         out_word__ENA;
   logic [31:0]  out_word_v;
   logic         out_word_last;
   logic         busy;
   logic [31:0]  msg_count;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   fifo_msg_serializer dut (
      .CLK           (CLK),
      .RST           (RST),
      .in_first      (in_first),
      .in_first__RDY (in_first__RDY),
      .in_deq__RDY   (in_deq__RDY),
      .in_deq__ENA   (in_deq__ENA),
      .out_word__RDY (out_word__RDY),
      .out_word__ENA (out_word__ENA),
      .out_word_v    (out_word_v),
      .out_word_last (out_word_last),
      .busy          (busy),
      .msg_count     (msg_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(posedge CLK) begin
      if (RST === 1'b0) begin
         n_assert++;
         if (out_word__ENA !== (busy & out_word__RDY)) begin
            n_fail++;
            $error("FAIL mon_word_ena observed=%0h expected=%0h", out_word__ENA, busy & out_word__RDY);
         end
         if (!busy && (out_word_v !== 32'h0)) begin
            n_fail++;
            $error("FAIL mon_v_idle observed=%0h expected=%0h", out_word_v, 32'h0);
         end
         if (in_deq__ENA && ((in_first__RDY & in_deq__RDY) !== 1'b1)) begin
            n_fail++;
            $error("FAIL mon_deq_gate observed=%0h expected=%0h", in_deq__ENA, 1'b0);
         end
      end
   end

   function automatic logic [703:0] make_msg(input logic [31:0] base);
      logic [703:0] m;
      for (int k = 0; k < 22; k++) m[32*k +: 32] = base + 32'(k);
      return m;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      in_first__RDY = 1'b0;
      in_deq__RDY = 1'b0;
      out_word__RDY = 1'b0;
      in_first = '0;
      tick();
      RST = 1'b0;
   endtask

   task automatic capture(input logic [31:0] base);
      in_first = make_msg(base);
      in_first__RDY = 1'b1;
      in_deq__RDY = 1'b1;
      out_word__RDY = 1'b1;
      #1;
      chk("cap_deq_ena", in_deq__ENA, 1'b1);
      chk("cap_busy", busy, 1'b0);
      chk("cap_word_ena", out_word__ENA, 1'b0);
      tick();
      in_first__RDY = 1'b0;
   endtask

   task automatic drain(input logic [31:0] base, input int start_k);
      for (int k = start_k; k < 22; k++) begin
         out_word__RDY = 1'b1;
         #1;
         chk("beat_ena", out_word__ENA, 1'b1);
         chk("beat_v", out_word_v, base + 32'(k));
         chk("beat_last", out_word_last, (k == 21));
         chk("beat_no_deq", in_deq__ENA, 1'b0);
         tick();
      end
   endtask

   initial begin
      do_reset();
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_word_ena", out_word__ENA, 1'b0);
      chk("rst_v", out_word_v, 32'h0);
      chk("rst_last", out_word_last, 1'b0);
      chk("rst_count", msg_count, 32'h0);
      chk("rst_deq_ena", in_deq__ENA, 1'b0);

      tick();
      capture(32'h1000_0000);
      drain(32'h1000_0000, 0);
      #1;
      chk("t1_busy_fall", busy, 1'b0);
      chk("t1_count", msg_count, 32'd1);

      do_reset();
      capture(32'h1000_0000);
      for (int k = 0; k < 22; k++) begin
         if (k >= 5) begin
            in_first = make_msg(32'h2000_0000);
            in_first__RDY = 1'b1;
         end
         #1;
         chk("t2_a_ena", out_word__ENA, 1'b1);
         chk("t2_a_v", out_word_v, 32'h1000_0000 + 32'(k));
         chk("t2_a_deq", in_deq__ENA, (k == 21));
         tick();
      end
      in_first__RDY = 1'b0;
      drain(32'h2000_0000, 0);
      #1;
      chk("t2_count", msg_count, 32'd2);
      chk("t2_busy", busy, 1'b0);

      do_reset();
      capture(32'h1000_0000);
      for (int k = 0; k < 22; k++) begin
         if (k == 3 || k == 21) begin
            out_word__RDY = 1'b0;
            if (k == 21) begin
               in_first = make_msg(32'h3000_0000);
               in_first__RDY = 1'b1;
            end
            for (int s = 0; s < 5; s++) begin
               #1;
               chk("t3_stall_ena", out_word__ENA, 1'b0);
               chk("t3_stall_v", out_word_v, 32'h1000_0000 + 32'(k));
               chk("t3_stall_busy", busy, 1'b1);
               chk("t3_stall_deq", in_deq__ENA, 1'b0);
               tick();
            end
            in_first__RDY = 1'b0;
         end
         out_word__RDY = 1'b1;
         #1;
         chk("t3_ena", out_word__ENA, 1'b1);
         chk("t3_v", out_word_v, 32'h1000_0000 + 32'(k));
         chk("t3_last", out_word_last, (k == 21));
         tick();
      end
      #1;
      chk("t3_count", msg_count, 32'd1);
      chk("t3_idle", busy, 1'b0);

      do_reset();
      in_first = make_msg(32'h4000_0000);
      in_first__RDY = 1'b1;
      in_deq__RDY = 1'b0;
      out_word__RDY = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("t4_gate_deq", in_deq__ENA, 1'b0);
         chk("t4_gate_busy", busy, 1'b0);
         chk("t4_gate_word", out_word__ENA, 1'b0);
         tick();
      end
      in_deq__RDY = 1'b1;
      #1;
      chk("t4_deq", in_deq__ENA, 1'b1);
      tick();
      in_first__RDY = 1'b0;
      #1;
      chk("t4_busy", busy, 1'b1);
      drain(32'h4000_0000, 0);

      do_reset();
      capture(32'h5000_0000);
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("t5_v", out_word_v, 32'h5000_0000 + 32'(k));
         tick();
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      #1;
      chk("t5_busy", busy, 1'b0);
      chk("t5_word_ena", out_word__ENA, 1'b0);
      chk("t5_count", msg_count, 32'h0);
      chk("t5_v_zero", out_word_v, 32'h0);
      tick();
      capture(32'h6000_0000);
      drain(32'h6000_0000, 0);
      #1;
      chk("t5_count_after", msg_count, 32'd1);

      do_reset();
      force dut.msg_count_q = 32'hFFFF_FFFF;
      tick();
      release dut.msg_count_q;
      #1;
      chk("t6_preset", msg_count, 32'hFFFF_FFFF);
      capture(32'h7000_0000);
      drain(32'h7000_0000, 0);
      #1;
      chk("t6_wrap", msg_count, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
